usb_cdc_tx_arbiter: RTL and testbench



---
 rtl/usb_cdc_tx_arbiter_if.sv | 24 ++
 rtl/usb_cdc_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_usb_cdc_tx_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_cdc_tx_arbiter_if.sv
// Byte-stream handshake bundle between the requesters, the TX arbiter and the
// usb_cdc_wrapper TX FIFO write port.
interface usb_cdc_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_fifo_full;
    logic                 tx_fifo_wr;
    logic [7:0]           tx_fifo_wdata;

    // Requesters plus FIFO status drive the arbiter
    modport master (
        output req_valid, req_last, req_data, tx_fifo_full,
        input  req_ready, tx_fifo_wr, tx_fifo_wdata
    );

    modport slave (
        input  req_valid, req_last, req_data, tx_fifo_full,
        output req_ready, tx_fifo_wr, tx_fifo_wdata
    );
endinterface

// File: rtl/usb_cdc_tx_arbiter.sv
// Round-robin burst arbiter sharing the USB CDC TX FIFO write port between
// NUM_REQ byte-stream requesters; a grant lasts until last, burst limit, idle timeout or en low.
module usb_cdc_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 8,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    usb_cdc_tx_arbiter_if.slave  bus,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 busy,
    output logic                 timeout_evt
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] BURST_LAST   = 8'(MAX_BURST - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(IDLE_TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] gnt_reg, gnt_next;
    logic [PTR_W-1:0]   g_idx_reg, g_idx_next;
    logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [7:0]         beat_cnt_reg, beat_cnt_next;
    logic [7:0]         idle_cnt_reg, idle_cnt_next;

    logic [7:0]         req_bytes [NUM_REQ];
    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   sel_idx;
    logic               sel_found;

    logic [NUM_REQ-1:0] ready_comb;
    logic               wr_comb;
    logic [7:0]         wdata_comb;
    logic               timeout_comb;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_bytes[gi] = bus.req_data[8*gi +: 8];
        end
    endgenerate

    // Cyclic search from rr_ptr; walking downward leaves the nearest hit in sel_idx.
    always_comb begin
        cand      = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = PTR_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
            if (bus.req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            gnt_reg      <= '0;
            g_idx_reg    <= '0;
            rr_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
            idle_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            g_idx_reg    <= g_idx_next;
            rr_ptr_reg   <= rr_ptr_next;
            beat_cnt_reg <= beat_cnt_next;
            idle_cnt_reg <= idle_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        g_idx_next    = g_idx_reg;
        rr_ptr_next   = rr_ptr_reg;
        beat_cnt_next = beat_cnt_reg;
        idle_cnt_next = idle_cnt_reg;
        ready_comb    = '0;
        wr_comb       = 1'b0;
        wdata_comb    = '0;
        timeout_comb  = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (en && sel_found) begin
                    state_next          = ST_BURST;
                    gnt_next            = '0;
                    gnt_next[sel_idx]   = 1'b1;
                    g_idx_next          = sel_idx;
                end
            end

            ST_BURST: begin
                ready_comb[g_idx_reg] = en & ~bus.tx_fifo_full;
                wr_comb      = bus.req_valid[g_idx_reg] & ready_comb[g_idx_reg];
                wdata_comb   = req_bytes[g_idx_reg];
                timeout_comb = ~bus.req_valid[g_idx_reg] && (idle_cnt_reg == TIMEOUT_LAST);

                // A valid byte stalled by a full FIFO leaves idle_cnt untouched.
                if (wr_comb) begin
                    beat_cnt_next = beat_cnt_reg + 8'd1;
                    idle_cnt_next = '0;
                end else if (!bus.req_valid[g_idx_reg]) begin
                    idle_cnt_next = idle_cnt_reg + 8'd1;
                end

                if (!en || timeout_comb ||
                    (wr_comb && (bus.req_last[g_idx_reg] || beat_cnt_reg == BURST_LAST))) begin
                    state_next    = ST_IDLE;
                    gnt_next      = '0;
                    rr_ptr_next   = (g_idx_reg == PTR_W'(NUM_REQ - 1)) ? '0 : g_idx_reg + 1'b1;
                    beat_cnt_next = '0;
                    idle_cnt_next = '0;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.req_ready     = ready_comb;
    assign bus.tx_fifo_wr    = wr_comb;
    assign bus.tx_fifo_wdata = wdata_comb;
    assign gnt               = gnt_reg;
    assign busy              = (state_reg == ST_BURST);
    assign timeout_evt       = timeout_comb;

endmodule

// File: tb/tb_usb_cdc_tx_arbiter.sv
// Self-checking bench for usb_cdc_tx_arbiter: directed vector table, hand-written
// corner sequences and constrained-random traffic against a transaction-level model.
module tb_usb_cdc_tx_arbiter;
    localparam int NUM_REQ      = 4;
    localparam int MAX_BURST    = 8;
    localparam int IDLE_TIMEOUT = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic [NUM_REQ-1:0] gnt;
    logic               busy;
    logic               timeout_evt;

    usb_cdc_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    usb_cdc_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .MAX_BURST(MAX_BURST),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .bus(bus.slave),
        .gnt(gnt),
        .busy(busy),
        .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source-side stimulus registers
    logic [NUM_REQ-1:0]   src_v, src_l;
    logic [8*NUM_REQ-1:0] src_d;

    task automatic drive();
        bus.req_valid = src_v;
        bus.req_last  = src_l;
        bus.req_data  = src_d;
    endtask

    // Reference model: who holds the grant, where the pointer is, and burst counters.
    int m_g = -1, m_rr = 0, m_beats = 0, m_idle = 0;
    bit m_wr, m_to, seen_to;
    logic [NUM_REQ-1:0] m_hs;
    int log_src[$];
    int log_dat[$];

    task automatic model_check();
        logic [NUM_REQ-1:0] e_gnt;
        logic [NUM_REQ-1:0] e_rdy;
        logic [7:0]         e_dat;
        e_gnt = '0; e_rdy = '0; e_dat = '0;
        m_wr = 1'b0; m_to = 1'b0; m_hs = '0;
        if (m_g >= 0) begin
            e_gnt[m_g] = 1'b1;
            e_rdy[m_g] = en && !bus.tx_fifo_full;
            m_wr  = bus.req_valid[m_g] && e_rdy[m_g];
            e_dat = bus.req_data[8*m_g +: 8];
            m_to  = !bus.req_valid[m_g] && (m_idle == IDLE_TIMEOUT - 1);
        end
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("busy", 32'(busy), 32'(m_g >= 0));
        chk("req_ready", 32'(bus.req_ready), 32'(e_rdy));
        chk("tx_fifo_wr", 32'(bus.tx_fifo_wr), 32'(m_wr));
        if (m_wr) chk("tx_fifo_wdata", 32'(bus.tx_fifo_wdata), 32'(e_dat));
        chk("timeout_evt", 32'(timeout_evt), 32'(m_to));
        seen_to = timeout_evt;
        if (m_wr) begin
            log_src.push_back(m_g);
            log_dat.push_back(int'(e_dat));
            m_hs[m_g] = 1'b1;
        end
    endtask

    task automatic model_advance();
        bit rel;
        bit found;
        if (m_g < 0) begin
            found = 1'b0;
            if (en) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (!found && bus.req_valid[(m_rr + k) % NUM_REQ]) begin
                        found = 1'b1;
                        m_g   = (m_rr + k) % NUM_REQ;
                    end
                end
            end
        end else begin
            rel = !en || m_to || (m_wr && (bus.req_last[m_g] || m_beats + 1 == MAX_BURST));
            if (m_wr) begin
                m_beats++;
                m_idle = 0;
            end else if (!bus.req_valid[m_g]) begin
                m_idle++;
            end
            if (rel) begin
                m_rr    = (m_g + 1) % NUM_REQ;
                m_g     = -1;
                m_beats = 0;
                m_idle  = 0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    // Asserting reset must clear every output at once, even mid-burst.
    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        src_v = '0; src_l = '0; src_d = '0;
        drive();
        bus.tx_fifo_full = 1'b0;
        m_g = -1; m_rr = 0; m_beats = 0; m_idle = 0; m_hs = '0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_wr", 32'(bus.tx_fifo_wr), 32'd0);
        chk("rst_timeout", 32'(timeout_evt), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic refresh(input int pv);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!src_v[i] || m_hs[i]) begin
                src_v[i]        = ($urandom_range(0, 99) < pv);
                src_d[8*i +: 8] = 8'($urandom);
                src_l[i]        = ($urandom_range(0, 3) == 0);
            end
        end
    endtask

    typedef struct {
        logic               en;
        logic               full;
        logic [NUM_REQ-1:0] v;
        logic [NUM_REQ-1:0] l;
        logic [31:0]        d;
        logic [NUM_REQ-1:0] e_gnt;
        logic [NUM_REQ-1:0] e_rdy;
        logic               e_wr;
        logic [7:0]         e_dat;
        logic               e_busy;
        logic               e_to;
    } vec_t;

    vec_t tv [14];

    initial begin
        int n2, cnt, to_cnt, k;
        bit found;

        tv[0]  = '{1'b1, 1'b0, 4'b0001, 4'b0000, 32'h41,   4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 4'b0001, 4'b0000, 32'h41,   4'b0001, 4'b0001, 1'b1, 8'h41, 1'b1, 1'b0};
        tv[2]  = '{1'b1, 1'b0, 4'b0001, 4'b0000, 32'h42,   4'b0001, 4'b0001, 1'b1, 8'h42, 1'b1, 1'b0};
        tv[3]  = '{1'b1, 1'b0, 4'b0001, 4'b0001, 32'h43,   4'b0001, 4'b0001, 1'b1, 8'h43, 1'b1, 1'b0};
        tv[4]  = '{1'b1, 1'b0, 4'b0011, 4'b0010, 32'h5544, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[5]  = '{1'b1, 1'b0, 4'b0011, 4'b0010, 32'h5544, 4'b0010, 4'b0010, 1'b1, 8'h55, 1'b1, 1'b0};
        tv[6]  = '{1'b1, 1'b0, 4'b0001, 4'b0000, 32'h41,   4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[7]  = '{1'b1, 1'b1, 4'b0001, 4'b0000, 32'h41,   4'b0001, 4'b0000, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 4'b0001, 4'b0000, 32'h41,   4'b0001, 4'b0000, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[9]  = '{1'b1, 1'b0, 4'b0001, 4'b0000, 32'h41,   4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[10] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 32'h00,   4'b0001, 4'b0001, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[11] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 32'h00,   4'b0001, 4'b0000, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[12] = '{1'b0, 1'b0, 4'b0001, 4'b0000, 32'h41,   4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[13] = '{1'b0, 1'b0, 4'b0001, 4'b0000, 32'h41,   4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0};

        bus.tx_fifo_full = 1'b0;
        do_reset();

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            en = tv[i].en;
            bus.tx_fifo_full = tv[i].full;
            bus.req_valid = tv[i].v;
            bus.req_last  = tv[i].l;
            bus.req_data  = tv[i].d;
            @(negedge clk);
            chk($sformatf("tv%0d_gnt", i), 32'(gnt), 32'(tv[i].e_gnt));
            chk($sformatf("tv%0d_ready", i), 32'(bus.req_ready), 32'(tv[i].e_rdy));
            chk($sformatf("tv%0d_wr", i), 32'(bus.tx_fifo_wr), 32'(tv[i].e_wr));
            if (tv[i].e_wr) chk($sformatf("tv%0d_wdata", i), 32'(bus.tx_fifo_wdata), 32'(tv[i].e_dat));
            chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].e_busy));
            chk($sformatf("tv%0d_timeout", i), 32'(timeout_evt), 32'(tv[i].e_to));
            $display("vector %0d: gnt=%b ready=%b wr=%b wdata=%h busy=%b", i, gnt, bus.req_ready,
                     bus.tx_fifo_wr, bus.tx_fifo_wdata, busy);
            @(posedge clk);
            #1;
        end

        // Round-robin: every requester always valid, last on every byte
        do_reset();
        log_src.delete(); log_dat.delete();
        en = 1'b1; src_v = 4'hF; src_l = 4'hF; src_d = 32'h30201000;
        repeat (10) begin
            drive();
            step();
            for (int i = 0; i < NUM_REQ; i++) if (m_hs[i]) src_d[8*i +: 8] += 8'd1;
        end
        chk("rr_count", 32'(log_src.size()), 32'd5);
        for (int i = 0; i < 5 && i < log_src.size(); i++)
            chk($sformatf("rr_order%0d", i), 32'(log_src[i]), 32'(i % NUM_REQ));
        $display("round-robin: %0d grants logged", log_src.size());

        // Burst limit: req2 streams 20 bytes without last while req1 waits
        do_reset();
        log_src.delete(); log_dat.delete();
        en = 1'b1; src_v = 4'b0100; src_l = 4'b0000; src_d = '0;
        drive();
        step();
        src_v[1] = 1'b1; src_l[1] = 1'b1; src_d[15:8] = 8'h90;
        n2 = 0;
        for (int c = 0; c < 200 && n2 < 20; c++) begin
            drive();
            step();
            if (m_hs[2]) begin
                n2++;
                src_d[23:16] = 8'(n2);
                if (n2 == 20) src_v[2] = 1'b0;
            end
            if (m_hs[1]) src_d[15:8] += 8'd1;
        end
        chk("burst_req2_bytes", 32'(n2), 32'd20);
        for (int i = 0; i < 10 && i < log_src.size(); i++) begin
            chk($sformatf("burst_src%0d", i), 32'(log_src[i]), (i < 8) ? 32'd2 : (i == 8) ? 32'd1 : 32'd2);
            chk($sformatf("burst_dat%0d", i), 32'(log_dat[i]), (i < 8) ? 32'(i) : (i == 8) ? 32'h90 : 32'd8);
        end
        $display("burst limit: %0d bytes logged", log_src.size());

        // Full stall for 50 cycles inside a req1 burst
        do_reset();
        log_src.delete(); log_dat.delete();
        en = 1'b1; src_v = 4'b0010; src_l = 4'b0000; src_d = 32'h00006000;
        for (int c = 0; c < 20 && log_src.size() < 2; c++) begin
            drive();
            step();
            if (m_hs[1]) src_d[15:8] += 8'd1;
        end
        bus.tx_fifo_full = 1'b1;
        cnt = log_src.size();
        to_cnt = 0;
        repeat (50) begin
            drive();
            step();
            to_cnt += int'(seen_to);
        end
        chk("stall_no_write", 32'(log_src.size()), 32'(cnt));
        chk("stall_no_timeout", 32'(to_cnt), 32'd0);
        bus.tx_fifo_full = 1'b0;
        drive();
        step();
        chk("stall_resume", 32'(log_src.size()), 32'(cnt + 1));
        $display("full stall: resumed with %0d bytes logged", log_src.size());

        // Idle timeout after a single byte from req3
        do_reset();
        en = 1'b1; src_v = 4'b1000; src_l = 4'b0000; src_d = 32'hAA000000;
        drive(); step();
        drive(); step();
        src_v = '0;
        drive();
        found = 1'b0;
        k = 0;
        for (int c = 1; c <= 40 && !found; c++) begin
            step();
            if (seen_to) begin
                found = 1'b1;
                k = c;
            end
        end
        chk("timeout_delay", 32'(k), 32'(IDLE_TIMEOUT));
        step();
        chk("timeout_gnt", 32'(gnt), 32'd0);
        chk("timeout_busy", 32'(busy), 32'd0);
        $display("timeout: pulse %0d cycles after last transfer", k);

        // Reset asserted mid-burst; do_reset checks outputs right away
        en = 1'b1; src_v = 4'b0001; src_l = 4'b0000; src_d = 32'h77;
        drive(); step();
        drive(); step();
        do_reset();
        $display("reset mid-burst: outputs cleared");

        // Random traffic: dense phase, then sparse phase that exercises timeouts
        for (int ph = 0; ph < 2; ph++) begin
            to_cnt = 0;
            log_src.delete(); log_dat.delete();
            for (int c = 0; c < 1500; c++) begin
                bus.tx_fifo_full = ($urandom_range(0, 99) < 15);
                en = ($urandom_range(0, 99) < 97);
                refresh((ph == 0) ? 60 : 6);
                drive();
                step();
                to_cnt += int'(seen_to);
            end
            $display("random phase %0d: %0d bytes, %0d timeouts", ph, log_src.size(), to_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
